// File: rtl/move_timer_pkg.sv
// Shared constants for the move timer and its period calculator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package move_timer_pkg;

  // Default period arithmetic width and speed/overrun widths
  localparam int DEF_CNT_W       = 26;
  localparam int DEF_SPEED_W     = 3;
  localparam int DEF_OVR_W       = 4;

  // Default game-step timing in clk cycles
  localparam int DEF_BASE_PERIOD = 25_000_000;
  localparam int DEF_STEP_PERIOD = 2_000_000;
  localparam int DEF_MIN_PERIOD  = 3_000_000;

  // Highest selectable speed level
  localparam int MAX_SPEED       = (2 ** DEF_SPEED_W) - 1;

endpackage

// File: rtl/move_period_calc.sv
// Maps a speed level to a step period: BASE - speed*STEP, clamped up to MIN.
// Latency: purely combinational.
// Backpressure: none; output follows input continuously.
module move_period_calc
  import move_timer_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP_PERIOD = DEF_STEP_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int SPEED_W     = DEF_SPEED_W
) (
  input  logic [SPEED_W-1:0] i_speed,
  output logic [CNT_W-1:0]   o_period
);

  // One spare bit above the product width so a negative difference shows in the MSB
  localparam int PW = CNT_W + SPEED_W + 1;

  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_diff;
  logic          w_neg;
  logic          w_low;

  assign w_prod   = PW'(i_speed) * PW'(STEP_PERIOD);
  assign w_diff   = PW'(BASE_PERIOD) - w_prod;
  assign w_neg    = w_diff[PW-1];
  assign w_low    = (w_diff < PW'(MIN_PERIOD));
  assign o_period = (w_neg || w_low) ? CNT_W'(MIN_PERIOD) : w_diff[CNT_W-1:0];

endmodule

// File: rtl/move_timer.sv
// Divides clk into game steps; raises a sticky move flag per step, counts steps lost to a pending flag.
// Latency: tick/move one cycle after the last count of a period; move clears one cycle after ack.
// Backpressure: none; unacknowledged steps are dropped and counted in a saturating overrun counter.
module move_timer
  import move_timer_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP_PERIOD = DEF_STEP_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int SPEED_W     = DEF_SPEED_W,
  parameter int OVR_W       = DEF_OVR_W
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic [SPEED_W-1:0] speed,
  input  logic               ack,
  input  logic               ovr_clr,
  output logic               move,
  output logic               tick,
  output logic [OVR_W-1:0]   ovr_cnt
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_tick;
  logic             r_move;
  logic [OVR_W-1:0] r_ovr;

  logic [CNT_W-1:0] w_period;
  logic             w_last;
  logic             w_wrap;
  logic             w_ovr_sat;

  move_period_calc #(
    .CNT_W       (CNT_W),
    .BASE_PERIOD (BASE_PERIOD),
    .STEP_PERIOD (STEP_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD),
    .SPEED_W     (SPEED_W)
  ) u_period_calc (
    .i_speed  (speed),
    .o_period (w_period)
  );

  // Wrap happens on the last count of the latched period, only while counting
  assign w_last    = (r_cnt == (r_period - CNT_W'(1)));
  assign w_wrap    = en && w_last;
  assign w_ovr_sat = &r_ovr;

  // Period counter: speed is only latched at a period boundary or while idle,
  // so a speed change never truncates a running period
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_period <= w_period;
    end else if (!en) begin
      r_cnt    <= '0;
      r_tick   <= 1'b0;
      r_period <= w_period;
    end else if (w_last) begin
      r_cnt    <= '0;
      r_tick   <= 1'b1;
      r_period <= w_period;
    end else begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_tick   <= 1'b0;
    end
  end

  // Sticky move flag: a new step overrides a same-cycle ack
  always_ff @(posedge clk) begin
    if (clr) begin
      r_move <= 1'b0;
    end else if (w_wrap) begin
      r_move <= 1'b1;
    end else if (ack) begin
      r_move <= 1'b0;
    end
  end

  // Overrun counter: a step is lost only if the previous one is still pending and not being acked
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ovr <= '0;
    end else if (ovr_clr) begin
      r_ovr <= '0;
    end else if (w_wrap && r_move && !ack && !w_ovr_sat) begin
      r_ovr <= r_ovr + OVR_W'(1);
    end
  end

  assign move    = r_move;
  assign tick    = r_tick;
  assign ovr_cnt = r_ovr;

endmodule

// File: tb/tb_move_timer.sv
// Bench for move_timer with a short-period configuration.
// Latency: n/a.
// Backpressure: n/a.
module tb_move_timer;
  import move_timer_pkg::*;

  logic       clk;
  logic       clr;
  logic       en;
  logic [2:0] speed;
  logic       ack;
  logic       ovr_clr;
  logic       move;
  logic       tick;
  logic [1:0] ovr_cnt;

  int n_chk;
  int n_err;

  move_timer #(
    .CNT_W       (8),
    .BASE_PERIOD (10),
    .STEP_PERIOD (2),
    .MIN_PERIOD  (3),
    .SPEED_W     (3),
    .OVR_W       (2)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .speed   (speed),
    .ack     (ack),
    .ovr_clr (ovr_clr),
    .move    (move),
    .tick    (tick),
    .ovr_cnt (ovr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step length for a speed level, straight from the game rules
  function automatic int step_len(int s);
    int p;
    p = 10 - 2 * s;
    if (p < 3) p = 3;
    return p;
  endfunction

  // Reference model: counts enabled cycles into the current step
  int m_el;
  int m_len;
  int m_ovr;
  bit m_move;
  bit m_tick;

  always @(posedge clk) begin : ref_model
    bit stp;
    stp = 1'b0;
    if (clr) begin
      m_el   = 0;
      m_len  = step_len(int'(speed));
      m_move = 1'b0;
      m_ovr  = 0;
      m_tick = 1'b0;
    end else begin
      if (en) begin
        m_el = m_el + 1;
        if (m_el == m_len) begin
          stp   = 1'b1;
          m_el  = 0;
          m_len = step_len(int'(speed));
        end
      end else begin
        m_el  = 0;
        m_len = step_len(int'(speed));
      end
      if (stp) begin
        if (m_move && !ack && m_ovr < 3) m_ovr = m_ovr + 1;
        m_move = 1'b1;
      end else if (ack) begin
        m_move = 1'b0;
      end
      if (ovr_clr) m_ovr = 0;
      m_tick = stp;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Cycles until tick is seen; bounded so a dead timer cannot hang the run
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 40);
  endtask

  task automatic restart(input logic [2:0] s);
    clr = 1'b1; en = 1'b0; ack = 1'b0; ovr_clr = 1'b0; speed = s;
    step();
    clr = 1'b0; en = 1'b1;
  endtask

  typedef struct {
    int         ncyc;
    logic       en;
    logic [2:0] speed;
    logic       ack;
    logic       ovr_clr;
    int         e_tick;
    int         e_move;
    int         e_ovr;
  } vec_t;

  vec_t vt[7];

  initial begin
    int n;
    n_chk = 0;
    n_err = 0;
    clr = 1'b1; en = 1'b0; speed = 3'd0; ack = 1'b0; ovr_clr = 1'b0;

    // Basic period at speed 0, no acks: overrun climbs then saturates
    vt[0] = '{9,  1'b1, 3'd0, 1'b0, 1'b0, 0, 0, 0};
    vt[1] = '{1,  1'b1, 3'd0, 1'b0, 1'b0, 1, 1, 0};
    vt[2] = '{1,  1'b1, 3'd0, 1'b0, 1'b0, 0, 1, 0};
    vt[3] = '{9,  1'b1, 3'd0, 1'b0, 1'b0, 1, 1, 1};
    vt[4] = '{10, 1'b1, 3'd0, 1'b0, 1'b0, 1, 1, 2};
    vt[5] = '{10, 1'b1, 3'd0, 1'b0, 1'b0, 1, 1, 3};
    vt[6] = '{10, 1'b1, 3'd0, 1'b0, 1'b0, 1, 1, 3};

    step();
    chk("reset_move", int'(move), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_ovr",  int'(ovr_cnt), 0);
    clr = 1'b0;

    for (int i = 0; i < 7; i++) begin
      en = vt[i].en; speed = vt[i].speed; ack = vt[i].ack; ovr_clr = vt[i].ovr_clr;
      steps(vt[i].ncyc);
      chk($sformatf("vec%0d_tick", i), int'(tick), vt[i].e_tick);
      chk($sformatf("vec%0d_move", i), int'(move), vt[i].e_move);
      chk($sformatf("vec%0d_ovr", i),  int'(ovr_cnt), vt[i].e_ovr);
    end

    // Clamp: speed 4 and speed 7 both floor at 3 cycles
    restart(3'd4);
    wait_tick(n);
    wait_tick(n);
    chk("clamp_s4_period", n, 3);
    restart(3'd7);
    wait_tick(n);
    wait_tick(n);
    chk("clamp_s7_period", n, 3);

    // Ack 4 cycles after a tick, then ack on the wrap cycle
    restart(3'd0);
    wait_tick(n);
    chk("ack_first_tick", n, 10);
    steps(3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_move_clr", int'(move), 0);
    chk("ack_ovr_hold", int'(ovr_cnt), 0);
    steps(6);
    chk("ack_next_tick", int'(tick), 1);
    chk("ack_next_move", int'(move), 1);
    steps(9);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("wrap_ack_tick", int'(tick), 1);
    chk("wrap_ack_move", int'(move), 1);
    chk("wrap_ack_ovr",  int'(ovr_cnt), 0);

    // Speed change mid-period applies from the following period
    restart(3'd0);
    wait_tick(n);
    steps(5);
    speed = 3'd2;
    wait_tick(n);
    chk("spd_cur_period", n, 5);
    wait_tick(n);
    chk("spd_next_period", n, 6);

    // Enable gap at cnt=7, then reset with a pending move
    restart(3'd0);
    wait_tick(n);
    steps(7);
    en = 1'b0;
    steps(5);
    chk("gap_move_held", int'(move), 1);
    chk("gap_tick_low",  int'(tick), 0);
    en = 1'b1;
    wait_tick(n);
    chk("gap_restart", n, 10);
    chk("gap_ovr", int'(ovr_cnt), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_move", int'(move), 0);
    chk("clr_ovr",  int'(ovr_cnt), 0);

    // ovr_clr on the same wrap that would increment
    restart(3'd4);
    for (int i = 0; i < 3; i++) wait_tick(n);
    chk("oc_pre_ovr", int'(ovr_cnt), 2);
    steps(2);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("oc_tick", int'(tick), 1);
    chk("oc_ovr",  int'(ovr_cnt), 0);

    // Random traffic against the reference model
    restart(3'd0);
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(9, 0) != 0);
      speed   = 3'($urandom_range(MAX_SPEED, 0));
      ack     = ($urandom_range(9, 0) == 0);
      ovr_clr = ($urandom_range(19, 0) == 0);
      clr     = ($urandom_range(199, 0) == 0);
      step();
      chk("rnd_move", int'(move), int'(m_move));
      chk("rnd_tick", int'(tick), int'(m_tick));
      chk("rnd_ovr",  int'(ovr_cnt), m_ovr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
